// File: rtl/cordic_vector.sv
// Iterative vectoring-mode CORDIC: one micro-rotation per clock, giving magnitude and atan2.
// Optional macro CORDIC_VECTOR_GAIN_COMP_EN scales Mag by K=0.60725 in the DONE cycle.
module cordic_vector #(
  parameter int ITERATIONS = 16  // legal 8..16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic signed [15:0] Xin,
  input  logic signed [15:0] Yin,
  output logic               busy,
  output logic               done,
  output logic        [17:0] Mag,
  output logic signed [18:0] Angle
);

  localparam logic signed [18:0] HALF_PI = 19'sd102944;
  localparam logic        [3:0]  LAST    = 4'(ITERATIONS - 1);

  typedef enum logic [1:0] {S_IDLE, S_ITER, S_DONE} state_t;

  state_t             r_state;
  logic signed [17:0] r_x, r_y;
  logic signed [18:0] r_z;
  logic        [3:0]  r_i;
  logic               r_zero;

  logic signed [17:0] w_xe, w_ye, w_x0, w_y0, w_xs, w_ys, w_xn, w_yn;
  logic signed [18:0] w_z0, w_zn, w_atan;
  logic        [17:0] w_mag;

  function automatic logic signed [18:0] atan_rom(input logic [3:0] idx);
    logic signed [18:0] v;
    case (idx)
      4'd0:    v = 19'sd51472;
      4'd1:    v = 19'sd30386;
      4'd2:    v = 19'sd16055;
      4'd3:    v = 19'sd8150;
      4'd4:    v = 19'sd4091;
      4'd5:    v = 19'sd2047;
      4'd6:    v = 19'sd1024;
      4'd7:    v = 19'sd512;
      4'd8:    v = 19'sd256;
      4'd9:    v = 19'sd128;
      4'd10:   v = 19'sd64;
      4'd11:   v = 19'sd32;
      4'd12:   v = 19'sd16;
      4'd13:   v = 19'sd8;
      4'd14:   v = 19'sd4;
      default: v = 19'sd2;
    endcase
    return v;
  endfunction

  assign w_xe = {{2{Xin[15]}}, Xin};
  assign w_ye = {{2{Yin[15]}}, Yin};

  // Left half-plane inputs are pre-rotated by +-90 deg so the iterations stay in range.
  always_comb begin
    w_x0 = w_xe;
    w_y0 = w_ye;
    w_z0 = '0;
    if (Xin[15]) begin
      if (!Yin[15]) begin
        w_x0 = w_ye;
        w_y0 = -w_xe;
        w_z0 = HALF_PI;
      end else begin
        w_x0 = -w_ye;
        w_y0 = w_xe;
        w_z0 = -HALF_PI;
      end
    end
  end

  assign w_xs   = r_x >>> r_i;
  assign w_ys   = r_y >>> r_i;
  assign w_atan = atan_rom(r_i);

  always_comb begin
    if (!r_y[17]) begin
      w_xn = r_x + w_ys;
      w_yn = r_y - w_xs;
      w_zn = r_z + w_atan;
    end else begin
      w_xn = r_x - w_ys;
      w_yn = r_y + w_xs;
      w_zn = r_z - w_atan;
    end
  end

`ifdef CORDIC_VECTOR_GAIN_COMP_EN
  logic [33:0] w_prod;
  // Final X is never negative in vectoring mode, so an unsigned multiply is exact.
  assign w_prod = 34'($unsigned(r_x)) * 34'd39797;
  assign w_mag  = 18'(w_prod >> 16);
`else
  assign w_mag  = $unsigned(r_x);
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_x     <= '0;
      r_y     <= '0;
      r_z     <= '0;
      r_i     <= '0;
      r_zero  <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
      Mag     <= '0;
      Angle   <= '0;
    end else begin
      done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_x     <= w_x0;
            r_y     <= w_y0;
            r_z     <= w_z0;
            r_i     <= '0;
            r_zero  <= (Xin == 16'sd0) && (Yin == 16'sd0);
            busy    <= 1'b1;
            r_state <= S_ITER;
          end
        end
        S_ITER: begin
          r_x <= w_xn;
          r_y <= w_yn;
          r_z <= w_zn;
          r_i <= r_i + 4'd1;
          if (r_i == LAST) r_state <= S_DONE;
        end
        S_DONE: begin
          // A zero vector has no defined angle; the iterations would drift Z, so force 0.
          Mag     <= r_zero ? '0 : w_mag;
          Angle   <= r_zero ? '0 : r_z;
          done    <= 1'b1;
          busy    <= 1'b0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cordic_vector.sv
// Bench for cordic_vector: ideal-math reference (sqrt/atan2) with tolerances, queue scoreboard.
module tb_cordic_vector;
  localparam int ITER  = 16;
  localparam int TOL_M = 16;
  localparam int TOL_A = 8;
`ifdef CORDIC_VECTOR_GAIN_COMP_EN
  localparam real KGAIN = 1.0;
`else
  localparam real KGAIN = 1.646760258;
`endif

  logic               clk = 1'b0;
  logic               rst, start;
  logic signed [15:0] Xin, Yin;
  logic               busy, done;
  logic        [17:0] Mag;
  logic signed [18:0] Angle;

  always #5 clk = ~clk;

  cordic_vector #(.ITERATIONS(ITER)) dut (
    .clk(clk), .rst(rst), .start(start), .Xin(Xin), .Yin(Yin),
    .busy(busy), .done(done), .Mag(Mag), .Angle(Angle)
  );

  typedef struct { int x; int y; int mag; int ang; string nm; } vec_t;
  typedef struct { int mag; int ang; int k; string nm; } exp_t;

  exp_t sb[$];
  exp_t e_cur;
  vec_t tbl[12];
  int   n_chk = 0, n_pass = 0, cyc = 0, n_done = 0;
  int   last_mag = 0, last_ang = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input int act, input int exp, input int tol);
    n_chk++;
    if (act >= exp - tol && act <= exp + tol) n_pass++;
    else $display("FAIL %s: got %0d, want %0d (+-%0d)", nm, act, exp, tol);
  endtask

  function automatic void model(input int x, input int y, output int m, output int a);
    real r;
    if (x == 0 && y == 0) begin
      m = 0;
      a = 0;
    end else begin
      r = $sqrt(real'(x) * real'(x) + real'(y) * real'(y));
      m = int'(r * KGAIN);
      a = int'($atan2(real'(y), real'(x)) * 65536.0);
    end
  endfunction

  // Result monitor: every done pops one expectation and checks value and latency.
  always @(negedge clk) begin
    if (done) begin
      n_done++;
      if (sb.size() == 0) chk("unexpected done", 1, 0, 0);
      else begin
        e_cur = sb.pop_front();
        chk({e_cur.nm, " mag"},     int'(Mag),   e_cur.mag, (e_cur.mag == 0) ? 0 : TOL_M);
        chk({e_cur.nm, " angle"},   int'(Angle), e_cur.ang, (e_cur.mag == 0) ? 0 : TOL_A);
        chk({e_cur.nm, " latency"}, cyc,         e_cur.k + ITER + 1, 0);
        last_mag = e_cur.mag;
        last_ang = e_cur.ang;
      end
    end
  end

  // Called at a negedge; waits for idle, pulses start for one cycle, returns the load edge index.
  task automatic issue(input int x, input int y, input int m, input int a,
                       input string nm, input bit push, output int k);
    int w;
    w = 0;
    while (busy && w < 100) begin @(negedge clk); w++; end
    if (busy) chk({nm, " idle wait"}, 1, 0, 0);
    start = 1'b1;
    Xin   = 16'(x);
    Yin   = 16'(y);
    k     = cyc + 1;
    if (push) sb.push_back('{m, a, k, nm});
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic issue_v(input int x, input int y, input string nm, output int k);
    int m, a;
    model(x, y, m, a);
    issue(x, y, m, a, nm, 1'b1, k);
  endtask

  task automatic drain();
    int w;
    w = 0;
    while (sb.size() != 0 && w < 200) begin @(negedge clk); w++; end
    chk("drain timeout", sb.size(), 0, 0);
  endtask

  initial begin
    int k1, k2, nd, x, y;
    tbl[0]  = '{ 32000,      0, 0, 0, "x+"};
    tbl[1]  = '{     0,  32000, 0, 0, "y+"};
    tbl[2]  = '{ 22627,  22627, 0, 0, "diag45"};
    tbl[3]  = '{-32000,      0, 0, 0, "x-"};
    tbl[4]  = '{-32000,     -1, 0, 0, "x- y-1"};
    tbl[5]  = '{     0, -32000, 0, 0, "y-"};
    tbl[6]  = '{     0,      0, 0, 0, "zero"};
    tbl[7]  = '{-32768, -32768, 0, 0, "min min"};
    tbl[8]  = '{-32768,      0, 0, 0, "min x"};
    tbl[9]  = '{ 32767, -32768, 0, 0, "max min"};
    tbl[10] = '{-20000,  15000, 0, 0, "q2"};
    tbl[11] = '{ 12345, -23456, 0, 0, "q4"};
    foreach (tbl[i]) model(tbl[i].x, tbl[i].y, tbl[i].mag, tbl[i].ang);

    rst = 1'b1; start = 1'b0; Xin = '0; Yin = '0;
    repeat (3) @(negedge clk);
    chk("reset busy",  int'(busy),  0, 0);
    chk("reset done",  int'(done),  0, 0);
    chk("reset mag",   int'(Mag),   0, 0);
    chk("reset angle", int'(Angle), 0, 0);
    rst = 1'b0;
    @(negedge clk);

    // Table vectors, issued back-to-back as soon as busy drops.
    foreach (tbl[i]) issue(tbl[i].x, tbl[i].y, tbl[i].mag, tbl[i].ang, tbl[i].nm, 1'b1, k1);
    drain();

    for (int r = 0; r < 8; r++) begin
      do begin
        x = int'($urandom_range(65535)) - 32768;
        y = int'($urandom_range(65535)) - 32768;
      end while (longint'(x) * x + longint'(y) * y < 64'd100000000);
      issue_v(x, y, "rand", k1);
    end
    drain();

    repeat (6) @(negedge clk);
    chk("hold mag",   int'(Mag),   last_mag, TOL_M);
    chk("hold angle", int'(Angle), last_ang, TOL_A);
    chk("idle done",  int'(done),  0, 0);

    // Back-to-back throughput and busy immediately after load.
    issue_v(30000, 5000, "b2b a", k1);
    chk("busy after load", int'(busy), 1, 0);
    issue_v(-7000, 25000, "b2b b", k2);
    chk("b2b spacing", k2 - k1, ITER + 2, 0);
    drain();

    // A second start mid-flight must not disturb the running operation.
    nd = n_done;
    issue_v(20000, 10000, "ovl", k1);
    repeat (4) @(negedge clk);
    start = 1'b1; Xin = -16'sd5000; Yin = -16'sd7000;
    @(negedge clk);
    start = 1'b0;
    drain();
    repeat (20) @(negedge clk);
    chk("ovl done count", n_done - nd, 1, 0);

    // Reset mid-operation aborts silently; start is accepted on the first cycle after.
    nd = n_done;
    issue(15000, -9000, 0, 0, "abort", 1'b0, k1);
    repeat (7) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("abort busy",  int'(busy),  0, 0);
    chk("abort mag",   int'(Mag),   0, 0);
    chk("abort angle", int'(Angle), 0, 0);
    rst = 1'b0;
    issue_v(-12000, -18000, "post rst", k2);
    drain();
    repeat (4) @(negedge clk);
    chk("abort done count", n_done - nd, 1, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/cordic_vector.md
CORDIC_VECTOR -- requirements
Module: cordic_vector

Interface
REQ-001 The block SHALL have parameter ITERATIONS, default 16, meaning the number of micro-rotations (legal 8..16).
REQ-002 The block SHALL have port clk, input, 1, the single clock; all state updates on rising edge.
REQ-003 The block SHALL have port rst, input, 1; reset is synchronous and active-high.
REQ-004 The block SHALL have port start, input, 1, request pulse; Xin/Yin are sampled on the same edge.
REQ-005 The block SHALL have port Xin, input, 16, signed two's-complement X coordinate.
REQ-006 The block SHALL have port Yin, input, 16, signed two's-complement Y coordinate.
REQ-007 The block SHALL have port busy, output, 1, high from the load edge until done is asserted.
REQ-008 The block SHALL have port done, output, 1, a one-cycle pulse marking valid Mag/Angle.
REQ-009 The block SHALL have port Mag, output, 18, an unsigned magnitude in Xin units.
REQ-010 The block SHALL have port Angle, output, 19, signed atan2(Yin,Xin) in radians, Q3.16 (pi/2 = 102944).

Function
REQ-011 The FSM SHALL have states IDLE, ITER and DONE; start is accepted only in IDLE.
REQ-012 IDLE with start=1 SHALL load the sign-extended 18-bit X/Y registers and the 19-bit Z register, clear the counter i, and go to ITER.
REQ-013 Load pre-rotation with Xin>=0 SHALL be X=Xin, Y=Yin, Z=0.
REQ-014 Load pre-rotation with Xin<0, Yin>=0 SHALL be X=Yin, Y=-Xin, Z=+102944.
REQ-015 Load pre-rotation with Xin<0, Yin<0 SHALL be X=-Yin, Y=Xin, Z=-102944.
REQ-016 Each ITER cycle with Y>=0 SHALL compute X+=Y>>>i, Y-=X>>>i, Z+=atan_i, using the old X/Y values and arithmetic shift (truncate).
REQ-017 Each ITER cycle with Y<0 SHALL compute X-=Y>>>i, Y+=X>>>i, Z-=atan_i.
REQ-018 The atan_i ROM, Q.16 for i=0..15, SHALL hold 51472, 30386, 16055, 8150, 4091, 2047, 1024, 512, 256, 128, 64, 32, 16, 8, 4, 2.
REQ-019 After iteration i=ITERATIONS-1, the FSM SHALL go to DONE; DONE SHALL register Mag and Angle, pulse done=1, drop busy, and return to IDLE.
REQ-020 Latency: start sampled at edge k SHALL give done=1 in the cycle after edge k+ITERATIONS+1 (k+17 at default).
REQ-021 Mag and Angle SHALL hold their values until the next DONE or a reset.
REQ-022 Back-to-back operation: start high in the cycle after done SHALL be accepted, for a throughput of one result per ITERATIONS+2 cycles.
REQ-023 start while busy=1 SHALL be ignored, with no effect on the in-flight operation or on later results.
REQ-024 Xin=0 and Yin=0 at load SHALL set a zero flag; that result SHALL be Mag=0, Angle=0.
REQ-025 Xin=-32768 and/or Yin=-32768 SHALL be handled without overflow; the 18-bit internal width covers 32768*sqrt(2)*1.6468.
REQ-026 Without gain compensation, Mag SHALL be the final X, equal to 1.6468*|v| within +-16 LSB.

Reset
REQ-027 rst=1 SHALL force IDLE, busy=0, done=0, Mag=0, Angle=0, and clear the counter and zero flag.
REQ-028 rst asserted mid-operation SHALL abort the operation, produce no done pulse, and accept start on the first cycle after rst deasserts.

Configuration
REQ-029 With macro CORDIC_VECTOR_GAIN_COMP_EN defined, DONE SHALL set Mag=(X*39797)>>16 (K=0.60725), without changing latency or Angle.
REQ-030 With CORDIC_VECTOR_GAIN_COMP_EN undefined, there SHALL be no multiplier, and Mag SHALL be the raw final X per REQ-026.

Verification
REQ-031 Xin=32000, Yin=0 -> done at k+17, Angle=0+-8, Mag=52696+-16 (32000+-16 with GAIN_COMP).
REQ-032 Xin=0, Yin=32000 -> Angle=102944+-8; Xin=22627, Yin=22627 -> Angle=51472+-8, Mag=52696+-16.
REQ-033 Xin=-32000, Yin=0 -> Angle=205887+-8; Xin=-32000, Yin=-1 -> Angle near -205887 (negative sign); Xin=0, Yin=-32000 -> Angle=-102944+-8.
REQ-034 Xin=0, Yin=0 -> Mag=0, Angle=0, done after 17 cycles.
REQ-035 start pulsed again at cycle k+5 -> ignored, single done at k+17 with the first operands' result.
REQ-036 rst at cycle k+8 -> no done pulse, outputs 0; a new start at the next cycle completes normally.
